// File: rtl/fifo_param_if.sv
// Handshake and status bundle for fifo_param.
// The requester side drives reads and writes; the FIFO side returns data and status.
// The read-data signal is named dout because "do" is a reserved word in SystemVerilog.
interface fifo_param_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             do_read;
    logic             do_write;
    logic [WIDTH-1:0] di;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             write_ack;
    logic             read_ack;
    logic             busy;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output do_read, do_write, di, clr_err,
        input  dout, write_ack, read_ack, busy, full, empty,
        input  almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  do_read, do_write, di, clr_err,
        output dout, write_ack, read_ack, busy, full, empty,
        output almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with a request/acknowledge handshake.
// It reports occupancy, almost-full and almost-empty thresholds, and sticky error flags.
module fifo_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 14,
    parameter int unsigned AE_LEVEL = 2
) (
    input logic         clk,
    input logic         reset,
    fifo_param_if.slave bus
);
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);
    localparam logic [AW:0] AfLevel   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AeLevel   = (AW+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             write_ack_q, read_ack_q;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             full, empty;
    logic             wr_en, rd_en;

    // Status decodes straight from the registered count.
    always_comb begin
        full  = (count_q == FullCount);
        empty = (count_q == '0);
    end

    // Accept rules: a write into a full FIFO is allowed when a read frees a slot on the same edge.
    always_comb begin
        rd_en = bus.do_read & ~empty;
        wr_en = bus.do_write & (~full | rd_en);
    end

    // Next-state for pointers, occupancy, read data and sticky errors.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem_q[rd_ptr_q];
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        // A new error on the same edge as clr_err wins over the clear.
        overflow_d  = (overflow_q & ~bus.clr_err) | (bus.do_write & ~wr_en);
        underflow_d = (underflow_q & ~bus.clr_err) | (bus.do_read & empty);
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            write_ack_q <= 1'b0;
            read_ack_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            write_ack_q <= wr_en;
            read_ack_q  <= rd_en;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array is never cleared; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem_q[wr_ptr_q] <= bus.di;
        end
    end

    // Drive the interface outputs.
    always_comb begin
        bus.dout         = dout_q;
        bus.write_ack    = write_ack_q;
        bus.read_ack     = read_ack_q;
        bus.full         = full;
        bus.busy         = full;
        bus.empty        = empty;
        bus.almost_full  = (count_q >= AfLevel);
        bus.almost_empty = (count_q <= AeLevel);
        bus.count        = count_q;
        bus.overflow     = overflow_q;
        bus.underflow    = underflow_q;
    end
endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param.
// A queue-based reference model checks every output on every cycle during directed and random traffic.
module tb_fifo_param;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AF    = 3;
    localparam int unsigned AE    = 1;

    logic clk = 1'b0;
    logic reset;

    fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [WIDTH-1:0] m_q [$];
    logic [WIDTH-1:0] m_dout;
    logic             m_wack, m_rack, m_ovf, m_udf;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then compare all outputs after the edge.
    task automatic step(input logic rst_n, input logic rd, input logic wr,
                        input logic [WIDTH-1:0] d, input logic clr);
        int  n;
        bit  can_rd, can_wr;
        reset        = rst_n;
        bus.do_read  = rd;
        bus.do_write = wr;
        bus.di       = d;
        bus.clr_err  = clr;
        if (!rst_n) begin
            m_q.delete();
            m_dout = '0;
            m_wack = 1'b0;
            m_rack = 1'b0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            n      = m_q.size();
            can_rd = rd && (n != 0);
            can_wr = wr && ((n < DEPTH) || can_rd);
            m_ovf  = (m_ovf && !clr) || (wr && !can_wr);
            m_udf  = (m_udf && !clr) || (rd && (n == 0));
            if (can_rd) m_dout = m_q.pop_front();
            if (can_wr) m_q.push_back(d);
            m_wack = can_wr;
            m_rack = can_rd;
        end
        @(posedge clk);
        #1;
        n = m_q.size();
        check_eq("dout", 32'(bus.dout), 32'(m_dout));
        check_eq("write_ack", 32'(bus.write_ack), 32'(m_wack));
        check_eq("read_ack", 32'(bus.read_ack), 32'(m_rack));
        check_eq("count", 32'(bus.count), n);
        check_eq("full", 32'(bus.full), 32'(n == DEPTH));
        check_eq("busy", 32'(bus.busy), 32'(n == DEPTH));
        check_eq("empty", 32'(bus.empty), 32'(n == 0));
        check_eq("almost_full", 32'(bus.almost_full), 32'(n >= AF));
        check_eq("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
        check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
        check_eq("underflow", 32'(bus.underflow), 32'(m_udf));
    endtask

    initial begin
        logic [WIDTH-1:0] t1 [3];
        logic [WIDTH-1:0] exp3 [4];
        int unsigned pr, pw;
        t1   = '{8'd42, 8'd25, 8'd32};
        exp3 = '{8'd2, 8'd3, 8'd4, 8'd9};
        reset        = 1'b0;
        bus.do_read  = 1'b0;
        bus.do_write = 1'b0;
        bus.di       = '0;
        bus.clr_err  = 1'b0;

        // 1: reset, three writes, three reads.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_eq("t1_reset_empty", 32'(bus.empty), 1);
        for (int i = 0; i < 3; i++) step(1, 0, 1, t1[i], 0);
        check_eq("t1_count", 32'(bus.count), 3);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0);
            check_eq("t1_dout", 32'(bus.dout), 32'(t1[i]));
        end
        check_eq("t1_end_empty", 32'(bus.empty), 1);

        // 2: overflow on a full FIFO, drain, clear.
        for (int i = 1; i <= 4; i++) step(1, 0, 1, 8'(i), 0);
        step(1, 0, 1, 8'd5, 0);
        check_eq("t2_overflow", 32'(bus.overflow), 1);
        check_eq("t2_no_wack", 32'(bus.write_ack), 0);
        for (int i = 1; i <= 4; i++) begin
            step(1, 1, 0, 0, 0);
            check_eq("t2_dout", 32'(bus.dout), i);
        end
        step(1, 0, 0, 0, 1);
        check_eq("t2_clr", 32'(bus.overflow), 0);

        // 3: simultaneous read and write while full.
        for (int i = 1; i <= 4; i++) step(1, 0, 1, 8'(i), 0);
        step(1, 1, 1, 8'd9, 0);
        check_eq("t3_dout", 32'(bus.dout), 1);
        check_eq("t3_count", 32'(bus.count), 4);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 0);
            check_eq("t3_drain", 32'(bus.dout), 32'(exp3[i]));
        end

        // 4: simultaneous read and write while empty.
        step(1, 1, 1, 8'd7, 0);
        check_eq("t4_underflow", 32'(bus.underflow), 1);
        check_eq("t4_no_rack", 32'(bus.read_ack), 0);
        step(1, 1, 0, 0, 1);
        check_eq("t4_dout", 32'(bus.dout), 7);

        // 5: 2-in/2-out through the wrap; also 3-deep to hit almost_full.
        for (int i = 0; i < 10; i += 2) begin
            step(1, 0, 1, 8'(i), 0);
            step(1, 0, 1, 8'(i + 1), 0);
            step(1, 1, 0, 0, 0);
            check_eq("t5_order", 32'(bus.dout), i);
            step(1, 1, 0, 0, 0);
            check_eq("t5_order", 32'(bus.dout), i + 1);
        end
        for (int i = 0; i < 3; i++) step(1, 0, 1, 8'(20 + i), 0);
        check_eq("t5_af", 32'(bus.almost_full), 1);

        // 6: reset mid-burst, then a read on the empty FIFO.
        step(0, 0, 1, 8'hee, 0);
        check_eq("t6_count", 32'(bus.count), 0);
        step(1, 1, 0, 0, 0);
        check_eq("t6_underflow", 32'(bus.underflow), 1);
        check_eq("t6_no_rack", 32'(bus.read_ack), 0);

        // Random traffic with shifting read/write bias to visit full and empty often.
        for (int i = 0; i < 2000; i++) begin
            if (i % 100 == 0) begin
                pr = $urandom_range(10, 90);
                pw = $urandom_range(10, 90);
            end
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) < pr),
                 ($urandom_range(0, 99) < pw), 8'($urandom), ($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO, the successor to the fixed 8-bit FIFO used by the 1-wire datapath.
- Configurable data width and depth.
- Level-sensitive request / one-cycle acknowledge handshake.
- Occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags.
- Sits between the 1-wire bit engine and the host bus interface, buffering RX and TX bytes.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; must be a power of two, >=2
AF_LEVEL, 14, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
(derived, not overridable) AW = clog2(DEPTH); count width AW+1

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
do_read  in  1  read request, level-sensitive, sampled each rising edge
do_write  in  1  write request, level-sensitive, sampled each rising edge
di  in  WIDTH  write data, sampled with do_write
do  out  WIDTH  read data, registered
write_ack  out  1  one-cycle pulse: write accepted on previous edge
read_ack  out  1  one-cycle pulse: do holds newly popped word
busy  out  1  high when FIFO cannot accept a write (== full)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  AW+1  current occupancy 0..DEPTH
overflow  out  1  sticky: write requested while full and not simultaneously read-accepted
underflow  out  1  sticky: read requested while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (reset==0 at rising edge):
  - wr_ptr, rd_ptr and count = 0; do = 0; write_ack, read_ack, overflow and underflow = 0.
  - empty=1, full=busy=0, almost_empty=1, almost_full = (AF_LEVEL==0 ? 1 : 0).
  - Memory contents are not cleared.
  - Reset dominates every other input, including mid-burst.
- Accept rules, evaluated on each edge with reset==1:
  - wr_en = do_write & (!full | rd_en).
  - rd_en = do_read & !empty.
- Write: mem[wr_ptr] <= di; wr_ptr wraps modulo DEPTH; write_ack=1 for the following cycle only.
- Read: do <= mem[rd_ptr]; rd_ptr wraps modulo DEPTH; read_ack=1 for the following cycle. Latency: request edge -> data valid one cycle later, coincident with read_ack.
- do holds its last value when no read is accepted.
- Requests held high are serviced every cycle; one word per cycle per direction.
- count update:
  - +1 on wr_en only; -1 on rd_en only; unchanged on both or neither.
  - Flags are derived from registered count. full, empty, busy, almost_full and almost_empty are combinational decodes of count, with no extra latency.
- Simultaneous read+write:
  - When full: both accepted, count stays DEPTH, write_ack=read_ack=1.
  - When empty: write accepted, read rejected (no read-through), underflow set.
- Errors:
  - overflow <= 1 when do_write & !wr_en.
  - underflow <= 1 when do_read & empty.
  - Rejected operations change no pointer, count or data.
  - clr_err clears both flags the next cycle. If a new error occurs on the same edge, set wins.
- Pointer wrap: after DEPTH writes and DEPTH reads the pointers return to 0, and data order is preserved across the wrap.

Test Plan:
1. DEPTH=4, WIDTH=8: reset low 2 cycles, then write 42, 25, 32 on consecutive cycles, then read 3 cycles -> write_ack pulses 3x, count 1,2,3; do = 42, 25, 32 with read_ack each cycle; empty=1 at end.
2. Fill 4 words (1,2,3,4), hold do_write with di=5 -> full=busy=1, no write_ack, overflow=1, count=4; subsequent reads return 1,2,3,4 (5 absent); clr_err clears overflow.
3. Full FIFO, do_read=do_write=1 with di=9 for 1 cycle -> read_ack returns 1, write_ack=1, count stays 4; draining yields 2,3,4,9.
4. Empty FIFO, do_read=1 and do_write=1 with di=7 -> write accepted, no read_ack, underflow=1, count=1; next read returns 7.
5. Wrap: write/read 10 words (0..9) interleaved 2-in/2-out through DEPTH=4 -> output order 0..9; almost_full (AF_LEVEL=3) and almost_empty (AE_LEVEL=1) toggle at count 3 and 1.
6. Reset asserted mid-burst with count=3 -> next cycle count=0, empty=1, acks and error flags 0; a following read gives underflow and no read_ack.
